// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions and exception codes.
// The PC-select logic and the pipeline import this same package.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE    = 0;
  localparam int unsigned SR_EXL   = 1;
  localparam int unsigned SR_IM_LO = 10;
  localparam int unsigned SR_IM_HI = 15;

  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/cp0_if.sv
// Bundle of the CP0 mfc0/mtc0 and commit-point signals, for benches and pipeline glue.
interface cp0_if;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pc_victim;
  logic        bd_victim;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        interrupt;
  logic        exception;
  logic [31:0] EPC;

  modport master (
    output raddr, we, waddr, wdata, pc_victim, bd_victim, exc_code_in, hw_int, eret,
    input  rdata, interrupt, exception, EPC
  );

  modport slave (
    input  raddr, we, waddr, wdata, pc_victim, bd_victim, exc_code_in, hw_int, eret,
    output rdata, interrupt, exception, EPC
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC and PRId with interrupt/exception acceptance and eret.
// Flat register file; accepted events take precedence over mtc0 and eret.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_victim,
  input  logic        bd_victim,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        interrupt,
  output logic        exception,
  output logic [31:0] EPC
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic        event_acc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^pc_victim[1:0];

  // Gated by reset so no event is reported while the registers are being cleared.
  assign interrupt = ~reset & (|(hw_int & im_q)) & ie_q & ~exl_q;
  assign exception = ~reset & (exc_code_in != 5'd0) & ~exl_q & ~interrupt;
  assign event_acc = interrupt | exception;
  assign EPC       = epc_q;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hw_int;
    exc_d = exc_q;
    epc_d = epc_q;
    if (event_acc) begin
      exl_d = 1'b1;
      bd_d  = bd_victim;
      exc_d = interrupt ? EXC_INT : exc_code_in;
      epc_d = {pc_victim[31:2], 2'b00} - (bd_victim ? 32'd4 : 32'd0);
    end else begin
      if (eret) begin
        exl_d = 1'b0;
      end
      if (we && (waddr == REG_SR)) begin
        im_d  = wdata[SR_IM_HI:SR_IM_LO];
        exl_d = wdata[SR_EXL];
        ie_d  = wdata[SR_IE];
      end
      if (we && (waddr == REG_EPC)) begin
        epc_d = {wdata[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    sr_word                        = '0;
    sr_word[SR_IE]                 = ie_q;
    sr_word[SR_EXL]                = exl_q;
    sr_word[SR_IM_HI:SR_IM_LO]     = im_q;
    cause_word                           = '0;
    cause_word[CAUSE_BD]                 = bd_q;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]  = ip_q;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
    rdata = '0;
    case (raddr)
      REG_SR:    rdata = sr_word;
      REG_CAUSE: rdata = cause_word;
      REG_EPC:   rdata = epc_q;
      REG_PRID:  rdata = PRID_VALUE;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have one clock, `clk`; reset is synchronous and active-high, named `reset`.
REQ-002 Parameter PRID_VALUE, default 32'h0000_0001; the value read from register 15.
REQ-003 Ports, in order (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- raddr  in  5  mfc0 register select
- rdata  out  32  mfc0 read data
- we  in  1  mtc0 write enable
- waddr  in  5  mtc0 register select
- wdata  in  32  mtc0 write data
- pc_victim  in  32  PC of the instruction at the commit point
- bd_victim  in  1  the victim sits in a branch delay slot
- exc_code_in  in  5  internal exception code; 0 = none
- hw_int  in  6  external interrupt lines [7:2]
- eret  in  1  eret at the commit point
- interrupt  out  1  interrupt accepted this cycle
- exception  out  1  internal exception accepted this cycle
- EPC  out  32  current EPC register value

Function
REQ-004 SHALL implement SR (reg 12), Cause (reg 13), EPC (reg 14) and PRId (reg 15); every other raddr SHALL read 0.
REQ-005 SR SHALL hold IM[15:10], EXL[1] and IE[0]; all other SR bits SHALL read 0.
REQ-006 Cause SHALL hold BD[31], IP[15:10] and ExcCode[6:2]; all other Cause bits SHALL read 0.
REQ-007 Cause.IP SHALL load hw_int on every clock edge. Cause SHALL NOT be writable by mtc0.
REQ-008 interrupt SHALL be combinational and equal (|(hw_int & SR.IM)) & SR.IE & !SR.EXL.
REQ-009 exception SHALL be combinational and equal (exc_code_in != 0) & !SR.EXL & !interrupt; interrupt has priority over exception.
REQ-010 An accepted event (interrupt | exception) SHALL cause the following updates on the next edge:
- SR.EXL <= 1
- Cause.BD <= bd_victim
- Cause.ExcCode <= 0 for an interrupt, exc_code_in for an exception
- EPC <= {pc_victim[31:2],2'b00} - (bd_victim ? 4 : 0)
REQ-011 eret with no accepted event SHALL clear SR.EXL on the next edge.
REQ-012 An mtc0 to SR SHALL write IM, EXL and IE; an mtc0 to EPC SHALL write {wdata[31:2],2'b00}; mtc0 writes to other addresses SHALL be ignored.
REQ-013 On a collision in one cycle, the accepted event SHALL win: a same-cycle mtc0 to SR or EPC is dropped, and a same-cycle eret is ignored.
REQ-014 rdata SHALL be combinational from current register state; there is no write-to-read bypass (mfc0 sees the old value in the same cycle).
REQ-015 EPC output SHALL be the registered EPC, valid in the cycle after capture.
REQ-016 EPC subtraction SHALL wrap modulo 2^32.

Reset
REQ-017 On reset the following SHALL be cleared:
- SR = 0, so IE = 0, EXL = 0, IM = 0
- Cause = 0
- EPC = 0
REQ-018 With reset asserted, interrupt and exception SHALL be 0 and all writes SHALL be suppressed; reset overrides every same-cycle event.

Structure
REQ-019 A shared constants file SHALL define register numbers (12–15), SR/Cause bit positions and ExcCode values (Int = 0, AdEL = 4, AdES = 5, RI = 10, Ov = 12); the PC-select logic and the pipeline SHALL include the same file.
REQ-020 The block SHALL be a single flat module with no sub-modules; the register file is small enough to implement inline.

Verification
REQ-021 Write SR = 32'h0000_FC01, then pulse hw_int = 6'b000100 -> interrupt = 1 that cycle; next cycle EXL = 1, Cause.ExcCode = 0 and interrupt = 0.
REQ-022 With SR.EXL = 0, drive exc_code_in = 12, pc_victim = 32'h0000_3010, bd_victim = 1 -> exception = 1; next cycle EPC = 32'h0000_300C and Cause = 32'h8000_0030.
REQ-023 Same cycle: hw_int enabled, exc_code_in = 4, mtc0 EPC = 32'h1234 -> interrupt = 1, exception = 0; ExcCode = 0 and EPC = pc_victim (the mtc0 is dropped).
REQ-024 With EXL = 1, pulse eret -> EXL = 0 next cycle; a pending enabled interrupt then asserts interrupt in the following cycle.
REQ-025 Set SR = 32'h0000_FC01, then assert reset for one cycle -> all registers read 0 (rdata at 12, 13, 14 = 0); rdata at 15 = PRID_VALUE; interrupt stays 0 under hw_int = 6'h3F.
REQ-026 mtc0 EPC = 32'h0000_4007 -> EPC reads 32'h0000_4004; mtc0 to Cause = 32'hFFFF_FFFF -> Cause unchanged.
